// File: rtl/jls_stream_fifo.sv
// Purpose: buffers the encoder's non-stallable word stream and re-presents it as valid/ready, with frame and overflow reporting.
// Latency: a word sampled at edge N is presented at o_valid after edge N+2 (registered RAM read, then output register).
// Backpressure: o_ready may stall the output indefinitely; the input cannot be stalled, so words arriving while full are dropped and flagged.
module jls_stream_fifo #(
    parameter int DW        = 64,
    parameter int AW        = 9,
    parameter int AF_MARGIN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_e,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [AW:0]   o_level,
    output logic          o_almost_full,
    output logic          o_overflow,
    output logic          o_frame_done,
    output logic [31:0]   o_frame_words
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Storage holds {last, data} per entry
    logic [DW:0]   mem [DEPTH];
    logic [DW:0]   rd_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   level;
    logic [AW:0]   level_nxt;
    // rd_q holds a valid copy of the RAM head (head was written before the read edge)
    logic          avail;
    logic          avail_nxt;
    logic          wr_en;
    logic          pop;
    logic          xfer;
    logic [31:0]   frame_cnt;
    logic [31:0]   cnt_inc;

    assign o_level = level;

    // Write/pop decisions, next read address and next level
    always_comb begin
        wr_en     = i_e && (level != FULL_LVL);
        xfer      = o_valid && o_ready;
        pop       = avail && (!o_valid || o_ready);
        rd_addr   = pop ? rd_ptr + PTR_ONE : rd_ptr;
        level_nxt = level;
        if (wr_en && !pop) begin
            level_nxt = level + LVL_ONE;
        end else if (!wr_en && pop) begin
            level_nxt = level - LVL_ONE;
        end
        // Words written on this edge cannot be read until the next one, so
        // only words already resident count towards the next head copy.
        avail_nxt = pop ? (level > LVL_ONE) : (level != '0);
        cnt_inc   = (frame_cnt == '1) ? frame_cnt : frame_cnt + 32'd1;
    end

    // RAM write port and registered read of the head the output stage will want next
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {i_last, i_data};
        end
        rd_q <= mem[rd_addr];
    end

    // Pointers, level, threshold flag and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            avail         <= 1'b0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level         <= level_nxt;
            avail         <= avail_nxt;
            o_almost_full <= (level_nxt >= AF_LVL);
            // Full is judged on the registered level, even if a pop frees a slot this edge
            if (i_e && !wr_en) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Output register: load the head when empty or handshaking, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (pop) begin
            o_valid <= 1'b1;
            o_last  <= rd_q[DW];
            o_data  <= rd_q[DW-1:0];
        end else if (xfer) begin
            o_valid <= 1'b0;
        end
    end

    // Per-frame word count on handshaken words, reported when the last word leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt     <= '0;
            o_frame_done  <= 1'b0;
            o_frame_words <= '0;
        end else begin
            o_frame_done <= xfer && o_last;
            if (xfer) begin
                if (o_last) begin
                    o_frame_words <= cnt_inc;
                    frame_cnt     <= '0;
                end else begin
                    frame_cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: doc/jls_stream_fifo.md
Name: jls_stream_fifo

Overview:
- Output-side buffer placed directly downstream of the uh_jls encoder.
- Accepts the encoder's 64-bit compressed word stream (o_e / o_data / o_last), which has no backpressure.
- Re-presents that stream as a valid/ready interface so a bus master or file sink may stall.
- Also reports per-frame word counts and a sticky overflow flag, because the encoder never stalls and dropped words must be visible.

Parameters:
- DW, 64, data word width; must match the encoder's o_data width.
- AW, 9, log2 of storage depth; 2^AW words of RAM, plus one output register.
- AF_MARGIN, 16, o_almost_full asserts when o_level >= 2^AW - AF_MARGIN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_e  in  1  input word strobe; connect to encoder o_e.
- i_data  in  DW  input word; connect to encoder o_data.
- i_last  in  1  last word of frame; connect to encoder o_last.
- o_valid  out  1  output word valid.
- o_ready  in  1  sink ready.
- o_data  out  DW  output word.
- o_last  out  1  last word of frame.
- o_level  out  AW+1  words held in RAM storage; excludes the output register.
- o_almost_full  out  1  level threshold flag.
- o_overflow  out  1  sticky: at least one input word was dropped.
- o_frame_done  out  1  one-cycle pulse after the last word of a frame is handshaken.
- o_frame_words  out  32  word count of the most recently completed frame.

Behaviour:
- Reset:
  - While rst is high at a clock edge, all outputs clear to 0 (o_valid, o_last, o_data, o_level, o_almost_full, o_overflow, o_frame_done, o_frame_words).
  - Read/write pointers and the internal frame counter also clear.
  - Reset mid-frame discards all stored and in-flight words; no frame_done is produced for the partial frame.
- Write:
  - An input word is written when i_e=1 and o_level < 2^AW.
  - {i_last, i_data} is stored together.
- Overflow:
  - When i_e=1 and o_level == 2^AW, the word is dropped and o_overflow is set; it stays set until rst.
  - This applies even if a pop happens in the same cycle; full is evaluated on the registered level.
  - A dropped word with i_last=1 is dropped like any other word; frame boundaries are then undefined until rst.
- Output stage:
  - Behaves as a registered first-word-fall-through stage.
  - When the output register is empty or handshaking (o_valid & o_ready), it loads the RAM head if o_level > 0.
  - Latency: into an empty block, a word sampled at edge N is presented with o_valid=1 after edge N+2 (RAM read, then output register).
  - Sustained throughput is 1 word/clock with o_ready held high.
- Handshake:
  - A transfer occurs on an edge where o_valid & o_ready.
  - While o_valid=1 and o_ready=0, o_data and o_last hold stable and o_valid stays 1.
  - o_valid never drops without a transfer, except on rst.
- Level:
  - o_level increments on a write and decrements on a RAM pop into the output register.
  - A write and a pop in the same cycle leave it unchanged.
  - Range is 0..2^AW; the pointers are AW bits and wrap modulo 2^AW.
- Almost full: o_almost_full is a registered compare of the next-state level.
- Frame accounting:
  - An internal 32-bit counter increments on each transfer.
  - On a transfer with o_last=1:
    - o_frame_words <= counter+1, and the counter resets to 0.
    - o_frame_done=1 for exactly the next cycle.
  - The counter saturates at 2^32-1.
  - Back-to-back frames may produce consecutive frame_done pulses.
- No state machine is required beyond the output-register full/empty state; an implementation within ~200 lines is expected.

Test Plan:
- Single frame, AW=9: 3 words A, B, C (C with i_last) on consecutive cycles, o_ready=1 → o_valid first high at edge 2 after A; A, B, C appear on consecutive cycles; o_last only with C; o_frame_done pulses once; o_frame_words=3; o_overflow=0.
- Backpressure: 4-word frame with o_ready toggled 1,0,0,1,... → each word is held stable through stall cycles; order is preserved; no duplicates or losses; o_frame_words=4.
- Overflow, AW=4: o_ready=0, then 20 consecutive i_e words:
  - 16 words stored in RAM plus 1 in the output register; o_level peaks at 16.
  - o_almost_full set once the level reaches 16-AF_MARGIN (set AF_MARGIN=4 for the bench, so at level 12).
  - o_overflow goes high on the first dropped word and stays high after draining.
  - 17 words drain, in order.
- Full with simultaneous pop: level=2^AW with i_e=1 and o_ready=1 on the same edge → input word dropped, o_overflow=1, level decrements to 2^AW-1.
- Reset mid-frame: rst pulsed for 1 cycle after 5 of 10 words → all outputs 0 on the next cycle; a following 2-word frame yields o_frame_words=2.
- Back-to-back frames: frames of 1, 1, and 7 words streamed with no gap, o_ready=1 → three o_frame_done pulses with o_frame_words 1, 1, 7.
